multicycle_seq: RTL and testbench

Parametrised stage sequencer for the multi-cycle LoongArch core. It owns the PC, the instruction register and the IF→ID→EXE→MEM→WB state machine. Instruction and data SRAM access use a req/addr_ok/data_ok handshake with variable latency instead of fixed single-cycle reads. If a handshake stalls, a watchdog traps the core. The decoder, ALU and regfile stay outside the block; it sits between them and the SRAM ports, and drives regfile write-enable and trace signals.

---
 rtl/multicycle_seq_pkg.sv | 13 +
 rtl/handshake_wait.sv | 35 +++
 rtl/multicycle_seq.sv | 120 ++++++++++++
 tb/tb_multicycle_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_seq_pkg.sv
// multicycle_seq_pkg: state encodings and core-wide constants shared by the sequencer, core top and trace checker
package multicycle_seq_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;
endpackage

// File: rtl/handshake_wait.sv
// handshake_wait: req/addr_ok/data_ok phase tracker with watchdog for one SRAM port
module handshake_wait #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_active,
  input  logic i_addr_ok,
  input  logic i_data_ok,
  output logic o_req,
  output logic o_done,
  output logic o_timeout
);
  logic       r_addr_done;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;
  logic       w_addr_done;
  // data_ok counts in the same cycle addr_ok is accepted; earlier data_ok is ignored
  always_comb begin
    o_req       = i_active && !r_addr_done;
    w_addr_done = r_addr_done || (o_req && i_addr_ok);
    o_done      = i_active && w_addr_done && i_data_ok;
    w_cnt_inc   = r_cnt + 8'd1;
    o_timeout   = i_active && !o_done && (w_cnt_inc == 8'(MAX_WAIT));
  end
  always_ff @(posedge clk) begin
    if (!resetn || !i_active || o_done) begin
      r_addr_done <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_addr_done <= w_addr_done;
      r_cnt       <= w_cnt_inc;
    end
  end
endmodule

// File: rtl/multicycle_seq.sv
// multicycle_seq: IF/ID/EXE/MEM/WB sequencer owning PC, IR and result register
// for the multi-cycle LoongArch core, with handshaked SRAM ports and a watchdog trap.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic [XLEN-1:0] ir,
  input  logic            dec_no_exe,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_gr_we,
  input  logic            dec_br_taken,
  input  logic [XLEN-1:0] dec_br_target,
  input  logic [XLEN-1:0] alu_result,
  output logic            data_req,
  output logic            data_wr,
  output logic [XLEN-1:0] data_addr,
  input  logic            data_addr_ok,
  input  logic            data_data_ok,
  input  logic [XLEN-1:0] data_rdata,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc,
  output logic [2:0]      state,
  output logic            err
);
  state_t            r_state, w_next;
  logic [XLEN-1:0]   r_pc, r_ir, r_result, r_br_target;
  logic              r_br_taken, r_is_load, r_is_store, r_gr_we, r_err;
  logic              w_if_req, w_if_done, w_if_to;
  logic              w_mem_req, w_mem_done, w_mem_to;
  logic [XLEN-1:0]   w_pc4, w_pc_next;
  handshake_wait #(.MAX_WAIT(MAX_WAIT)) u_if_wait (
    .clk       (clk),
    .resetn    (resetn),
    .i_active  (resetn && r_state == S_IF),
    .i_addr_ok (inst_addr_ok),
    .i_data_ok (inst_data_ok),
    .o_req     (w_if_req),
    .o_done    (w_if_done),
    .o_timeout (w_if_to)
  );
  handshake_wait #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
    .clk       (clk),
    .resetn    (resetn),
    .i_active  (resetn && r_state == S_MEM),
    .i_addr_ok (data_addr_ok),
    .i_data_ok (data_data_ok),
    .o_req     (w_mem_req),
    .o_done    (w_mem_done),
    .o_timeout (w_mem_to)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:    w_next = w_if_to ? S_TRAP : w_if_done ? S_ID : S_IF;
      S_ID:    w_next = dec_no_exe ? S_IF : S_EXE;
      S_EXE:   w_next = (r_is_load || r_is_store) ? S_MEM : S_WB;
      S_MEM:   w_next = w_mem_to ? S_TRAP : !w_mem_done ? S_MEM : r_is_load ? S_WB : S_IF;
      S_WB:    w_next = S_IF;
      default: w_next = S_TRAP;
    endcase
  end
  always_comb begin
    inst_req  = w_if_req;
    inst_addr = r_pc;
    ir        = r_ir;
    data_req  = w_mem_req;
    data_wr   = w_mem_req && r_is_store;
    data_addr = r_result;
    rf_we     = r_state == S_WB && r_gr_we;
    rf_wdata  = r_result;
    retire    = (r_state == S_ID && dec_no_exe) || (w_mem_done && r_is_store) || r_state == S_WB;
    retire_pc = r_pc;
    state     = r_state;
    err       = r_err;
    w_pc4     = r_pc + 32'd4;
    // branches redirect from ID using live decode; jirl/bl redirect from WB using the latched copy
    w_pc_next = r_state == S_ID ? (dec_br_taken ? dec_br_target : w_pc4) :
                (r_state == S_WB && r_br_taken) ? r_br_target : w_pc4;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IF;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_result    <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_gr_we     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_if_done) r_ir <= inst_rdata;
      if (r_state == S_ID) begin
        r_br_taken  <= dec_br_taken;
        r_br_target <= dec_br_target;
        r_is_load   <= dec_is_load;
        r_is_store  <= dec_is_store;
        r_gr_we     <= dec_gr_we;
      end
      if (r_state == S_EXE) r_result <= alu_result;
      if (w_mem_done && r_is_load) r_result <= data_rdata;
      if (retire) r_pc <= w_pc_next;
      if (w_if_to || w_mem_to) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: randomized instruction stream against a per-instruction stage-timeline model
module tb_multicycle_seq;
  localparam int ALU = 0, BR = 1, LD = 2, ST = 3, JL = 4;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req, inst_addr_ok, inst_data_ok, dec_no_exe, dec_is_load, dec_is_store;
  logic        dec_gr_we, dec_br_taken, data_req, data_wr, data_addr_ok, data_data_ok;
  logic        rf_we, retire, err;
  logic [31:0] inst_addr, inst_rdata, ir, dec_br_target, alu_result, data_addr, data_rdata;
  logic [31:0] rf_wdata, retire_pc;
  logic [2:0]  state;
  int          checks = 0, errors = 0;
  logic [31:0] mpc, obs_rpc, obs_wd;
  int          obs_len;
  logic        obs_rfwe, obs_exe;
  multicycle_seq dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .ir(ir),
    .dec_no_exe(dec_no_exe), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_gr_we(dec_gr_we), .dec_br_taken(dec_br_taken), .dec_br_target(dec_br_target),
    .alu_result(alu_result), .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .retire(retire), .retire_pc(retire_pc),
    .state(state), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (model pc %h)", nm, act, exp, mpc);
    end
  endtask
  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask
  // everything not driven with meaning in a given cycle is random, so stray use is caught
  task automatic noise();
    inst_addr_ok = 1'($urandom); inst_data_ok = 1'($urandom); inst_rdata = $urandom;
    data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom); data_rdata = $urandom;
    dec_no_exe = 1'($urandom); dec_is_load = 1'($urandom); dec_is_store = 1'($urandom);
    dec_gr_we = 1'($urandom); dec_br_taken = 1'($urandom); dec_br_target = $urandom;
    alu_result = $urandom;
  endtask
  task automatic observe();
    obs_len++;
    if (retire) obs_rpc = retire_pc;
    if (rf_we) begin obs_rfwe = 1'b1; obs_wd = rf_wdata; end
    if (state == 3'd2) obs_exe = 1'b1;
  endtask
  // One instruction: IF takes ia+idd+1 cycles, ID 1, EXE 1 unless branch, MEM da+dd+1 for ld/st,
  // WB 1 for ALU/load/jirl. rst_at>=0 pulls resetn low in that MEM cycle.
  task automatic run_instr(input int cls, input int ia, input int idd, input int da, input int dd,
                           input logic tk, input logic [31:0] tgt, input logic gw,
                           input logic [31:0] alu, input logic [31:0] rd, input int rst_at);
    logic [31:0] word;
    word = $urandom;
    obs_len = 0; obs_rfwe = 1'b0; obs_exe = 1'b0; obs_rpc = 32'hx; obs_wd = 32'hx;
    for (int k = 0; k <= ia + idd; k++) begin
      noise();
      inst_addr_ok = (k == ia); inst_data_ok = (k == ia + idd);
      if (k == ia + idd) inst_rdata = word;
      #1 observe();
      chk("if_state", 32'(state), 32'd0);
      chkb("if_req", inst_req, k <= ia);
      if (k <= ia) chk("if_addr", inst_addr, mpc);
      chkb("if_retire", retire, 1'b0);
      chkb("if_dreq", data_req, 1'b0);
      @(negedge clk);
    end
    noise();
    dec_no_exe = (cls == BR); dec_is_load = (cls == LD); dec_is_store = (cls == ST);
    dec_gr_we = gw; dec_br_taken = tk; dec_br_target = tgt;
    #1 observe();
    chk("id_state", 32'(state), 32'd1);
    chk("id_ir", ir, word);
    chkb("id_retire", retire, cls == BR);
    if (cls == BR) chk("id_retire_pc", retire_pc, mpc);
    chkb("id_ireq", inst_req, 1'b0);
    chkb("id_rfwe", rf_we, 1'b0);
    @(negedge clk);
    if (cls == BR) begin mpc = tk ? tgt : mpc + 32'd4; return; end
    noise(); alu_result = alu;
    #1 observe();
    chk("exe_state", 32'(state), 32'd2);
    chkb("exe_ireq", inst_req, 1'b0);
    chkb("exe_dreq", data_req, 1'b0);
    chkb("exe_retire", retire, 1'b0);
    @(negedge clk);
    if (cls == LD || cls == ST) begin
      for (int k = 0; k <= da + dd; k++) begin
        noise();
        data_addr_ok = (k == da); data_data_ok = (k == da + dd);
        if (k == da + dd) data_rdata = rd;
        if (k == rst_at) begin resetn = 1'b0; data_data_ok = 1'b0; end
        #1 observe();
        chk("mem_state", 32'(state), 32'd3);
        if (k == rst_at) begin
          @(negedge clk);
          resetn = 1'b1; noise(); inst_addr_ok = 1'b0; inst_data_ok = 1'b0; data_data_ok = 1'b1;
          #1 chk("rst_state", 32'(state), 32'd0);
          chkb("rst_ireq", inst_req, 1'b1);
          chk("rst_addr", inst_addr, 32'h1c00_0000);
          chkb("rst_retire", retire, 1'b0);
          chkb("rst_err", err, 1'b0);
          @(negedge clk);
          noise(); inst_addr_ok = 1'b0; inst_data_ok = 1'b0; data_data_ok = 1'b0;
          #1 chk("rst_ign_state", 32'(state), 32'd0);
          chkb("rst_ign_retire", retire, 1'b0);
          @(negedge clk);
          mpc = 32'h1c00_0000;
          return;
        end
        chkb("mem_req", data_req, k <= da);
        if (k <= da) begin
          chkb("mem_wr", data_wr, cls == ST);
          chk("mem_addr", data_addr, alu);
        end
        chkb("mem_retire", retire, cls == ST && k == da + dd);
        if (cls == ST && k == da + dd) chk("mem_retire_pc", retire_pc, mpc);
        chkb("mem_ireq", inst_req, 1'b0);
        chkb("mem_rfwe", rf_we, 1'b0);
        @(negedge clk);
      end
      if (cls == ST) begin mpc = mpc + 32'd4; return; end
    end
    noise();
    #1 observe();
    chk("wb_state", 32'(state), 32'd4);
    chkb("wb_rfwe", rf_we, gw);
    if (gw) chk("wb_wdata", rf_wdata, cls == LD ? rd : alu);
    chkb("wb_retire", retire, 1'b1);
    chk("wb_retire_pc", retire_pc, mpc);
    chkb("wb_ireq", inst_req, 1'b0);
    chkb("wb_dreq", data_req, 1'b0);
    @(negedge clk);
    mpc = tk ? tgt : mpc + 32'd4;
  endtask
  task automatic rnd();
    int c;
    c = int'($urandom_range(0, 4));
    run_instr(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              c == JL || (c == BR && 1'($urandom)), $urandom & 32'hFFFF_FFFC,
              c == LD || c == JL || (c == ALU && $urandom_range(0, 3) != 0),
              c == JL ? mpc + 32'd4 : $urandom, $urandom, -1);
  endtask
  initial begin
    noise();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", inst_addr, 32'h1c00_0000);
    chk("reset_ir", ir, 32'd0);
    chk("reset_result", rf_wdata, 32'd0);
    chkb("reset_ireq", inst_req, 1'b0);
    chkb("reset_dreq", data_req, 1'b0);
    chkb("reset_rfwe", rf_we, 1'b0);
    chkb("reset_retire", retire, 1'b0);
    chkb("reset_err", err, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    mpc = 32'h1c00_0000;
    run_instr(ALU, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1, 32'h0000_1234, 32'd0, -1);
    chk("pin_add_retire_pc", obs_rpc, 32'h1c00_0000);
    chk("pin_add_len", 32'(obs_len), 32'd4);
    chkb("pin_add_rfwe", obs_rfwe, 1'b1);
    chk("pin_add_next_pc", inst_addr, 32'h1c00_0004);
    repeat (3) run_instr(ALU, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1, $urandom, 32'd0, -1);
    run_instr(LD, 0, 0, 2, 3, 1'b0, 32'd0, 1'b1, 32'h0000_0800, 32'hdead_beef, -1);
    chk("pin_load_wdata", obs_wd, 32'hdead_beef);
    chk("pin_load_len", 32'(obs_len), 32'd10);
    chk("pin_load_retire_pc", obs_rpc, 32'h1c00_0010);
    run_instr(BR, 0, 0, 0, 0, 1'b1, 32'h1c00_0100, 1'b0, 32'd0, 32'd0, -1);
    chk("pin_beq_len", 32'(obs_len), 32'd2);
    chk("pin_beq_next_pc", inst_addr, 32'h1c00_0100);
    chkb("pin_beq_rfwe", obs_rfwe, 1'b0);
    chkb("pin_beq_exe", obs_exe, 1'b0);
    run_instr(ALU, 10, 4, 0, 0, 1'b0, 32'd0, 1'b1, $urandom, 32'd0, -1);
    chkb("pin_if_edge_err", err, 1'b0);
    run_instr(LD, 0, 0, 10, 4, 1'b0, 32'd0, 1'b1, $urandom, $urandom, -1);
    chkb("pin_mem_edge_err", err, 1'b0);
    run_instr(BR, 1, 1, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, -1);
    run_instr(ALU, 0, 1, 0, 0, 1'b0, 32'd0, 1'b1, $urandom, 32'd0, -1);
    chk("pin_pc_wrap", inst_addr, 32'h0000_0000);
    for (int i = 0; i < 300; i++) rnd();
    run_instr(ST, 0, 0, 1, 2, 1'b0, 32'd0, 1'b0, $urandom, $urandom, 1);
    run_instr(ALU, 1, 2, 0, 0, 1'b0, 32'd0, 1'b1, $urandom, 32'd0, -1);
    for (int k = 0; k < 15; k++) begin
      noise(); inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      #1 chk("trap_wait_state", 32'(state), 32'd0);
      chkb("trap_wait_req", inst_req, 1'b1);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      noise();
      #1 chk("trap_state", 32'(state), 32'd7);
      chkb("trap_err", err, 1'b1);
      chkb("trap_ireq", inst_req, 1'b0);
      chkb("trap_dreq", data_req, 1'b0);
      chkb("trap_retire", retire, 1'b0);
      @(negedge clk);
    end
    resetn = 1'b0;
    @(negedge clk);
    #1 chk("trap_rst_state", 32'(state), 32'd0);
    chk("trap_rst_pc", inst_addr, 32'h1c00_0000);
    chkb("trap_rst_err", err, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    mpc = 32'h1c00_0000;
    run_instr(JL, 0, 0, 0, 0, 1'b1, 32'h1c00_0200, 1'b1, mpc + 32'd4, 32'd0, -1);
    chk("pin_bl_wdata", obs_wd, 32'h1c00_0004);
    chk("pin_bl_next_pc", inst_addr, 32'h1c00_0200);
    for (int i = 0; i < 50; i++) rnd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
